// File: rtl/gold_pkg.sv
// gold_pkg: shared widths, ceiling and FSM state type for the gold counter slice.
package gold_pkg;
   localparam int GOLD_W   = 3;
   localparam int MAX_GOLD = 4;
   typedef enum logic [1:0] {ARMED = 2'd0, HIT = 2'd1, COOLDOWN = 2'd2} gold_state_e;
endpackage

// File: rtl/gold_frame_timer.sv
// gold_frame_timer: loadable down-counter stepped by startOfFrame, with zero flag.
module gold_frame_timer #(
   parameter int W = 4,
   parameter logic [W-1:0] INIT = '0,
   parameter bit RELOAD = 1'b0,
   parameter logic [W-1:0] RELOAD_VAL = '0
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   assign zero = cnt_q == '0;
   always_comb
      cnt_d = clr ? INIT : load ? load_val : !tick ? cnt_q : !zero ? cnt_q - 1'b1 : RELOAD ? RELOAD_VAL : cnt_q;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) cnt_q <= INIT;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/gold_counter.sv
// gold_counter: one collect per frame, saturating gold count, spend grant/refuse for the HUD.
// Define GOLD_COUNTER_DECAY_EN to lose one gold every DECAY_FRAMES frames.
module gold_counter #(
   parameter int GOLD_W          = gold_pkg::GOLD_W,
   parameter int MAX_GOLD        = gold_pkg::MAX_GOLD,
   parameter int SPEND_COST      = 2,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int DECAY_FRAMES    = 600
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              startOfFrame,
   input  logic              collision_tank_gold,
   input  logic              new_game,
   input  logic              spend_req,
   output logic [GOLD_W-1:0] more_gold,
   output logic              gold_taken,
   output logic              spend_ack,
   output logic              spend_nack,
   output logic              gold_full
);
   import gold_pkg::*;
   localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [GOLD_W:0] MAX_V  = (GOLD_W + 1)'(MAX_GOLD);
   localparam logic [GOLD_W:0] COST_V = (GOLD_W + 1)'(SPEND_COST);
   gold_state_e state_q, state_d;
   logic [GOLD_W-1:0] count_q, count_d;
   logic [GOLD_W:0] dec, sum;
   logic gold_taken_q, spend_ack_q, spend_nack_q, gold_full_q;
   logic commit, grant, decay_step, cd_zero;
   assign commit = state_q == HIT && startOfFrame;
   assign grant  = spend_req && {1'b0, count_q} >= COST_V;
   gold_frame_timer #(.W(CW)) u_cooldown (
      .clk, .resetN, .clr(new_game), .load(commit), .load_val(CW'(COOLDOWN_FRAMES - 1)),
      .tick(startOfFrame), .zero(cd_zero)
   );
`ifdef GOLD_COUNTER_DECAY_EN
   localparam int DW = $clog2(DECAY_FRAMES + 1);
   logic decay_zero;
   gold_frame_timer #(.W(DW), .INIT(DW'(DECAY_FRAMES - 1)), .RELOAD(1'b1), .RELOAD_VAL(DW'(DECAY_FRAMES - 1))) u_decay (
      .clk, .resetN, .clr(new_game), .load(1'b0), .load_val('0), .tick(startOfFrame), .zero(decay_zero)
   );
   // a decay blocked by a collect or spend is dropped, not deferred
   assign decay_step = startOfFrame && decay_zero && count_q != '0 && !commit && !grant;
`else
   assign decay_step = 1'b0;
`endif
   always_comb begin
      dec     = grant ? COST_V : {{GOLD_W{1'b0}}, decay_step};
      sum     = {1'b0, count_q} + {{GOLD_W{1'b0}}, commit} - dec;
      count_d = new_game ? '0 : sum > MAX_V ? MAX_V[GOLD_W-1:0] : sum[GOLD_W-1:0];
      state_d = new_game ? ARMED :
                (state_q == ARMED && collision_tank_gold) ? HIT :
                commit ? COOLDOWN :
                (state_q == COOLDOWN && startOfFrame && cd_zero) ? ARMED : state_q;
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state_q      <= ARMED;
         count_q      <= '0;
         gold_taken_q <= 1'b0;
         spend_ack_q  <= 1'b0;
         spend_nack_q <= 1'b0;
         gold_full_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         gold_taken_q <= commit && !new_game;
         spend_ack_q  <= grant && !new_game;
         spend_nack_q <= spend_req && !grant && !new_game;
         gold_full_q  <= {1'b0, count_d} == MAX_V;
      end
   assign more_gold  = count_q;
   assign gold_taken = gold_taken_q;
   assign spend_ack  = spend_ack_q;
   assign spend_nack = spend_nack_q;
   assign gold_full  = gold_full_q;
endmodule

// File: tb/tb_gold_counter.sv
// tb_gold_counter: directed checks of collect, cooldown, saturation, spend and new_game.
module tb_gold_counter;
   import gold_pkg::*;
   logic clk = 1'b0, resetN = 1'b0;
   logic startOfFrame = 1'b0, collision_tank_gold = 1'b0, new_game = 1'b0, spend_req = 1'b0;
   logic [2:0] more_gold;
   logic gold_taken, spend_ack, spend_nack, gold_full;
   int tests = 0, fails = 0;
   logic [31:0] mask;

   gold_counter dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision_tank_gold(collision_tank_gold),
      .new_game(new_game), .spend_req(spend_req), .more_gold(more_gold), .gold_taken(gold_taken),
      .spend_ack(spend_ack), .spend_nack(spend_nack), .gold_full(gold_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic sof;
      startOfFrame = 1'b1;
      step;
      startOfFrame = 1'b0;
   endtask

   task automatic collect(input logic spend);
      collision_tank_gold = 1'b1;
      step;
      collision_tank_gold = 1'b0;
      step;
      startOfFrame = 1'b1;
      spend_req = spend;
      step;
      startOfFrame = 1'b0;
      spend_req = 1'b0;
   endtask

   task automatic cool;
      repeat (8) begin
         sof;
         step;
      end
   endtask

   task automatic ng;
      new_game = 1'b1;
      step;
      new_game = 1'b0;
   endtask

   task automatic spend;
      spend_req = 1'b1;
      step;
      spend_req = 1'b0;
   endtask

   initial begin
      repeat (2) step;
      check("rst_count", more_gold, 0);
      check("rst_pulses", {gold_taken, spend_ack, spend_nack, gold_full}, 0);
      check("rst_state", dut.state_q, ARMED);
      resetN = 1'b1;
      step;
      collision_tank_gold = 1'b1;
      repeat (50) step;
      check("hold_state", dut.state_q, HIT);
      check("hold_count", more_gold, 0);
      sof;
      check("first_taken", gold_taken, 1);
      check("first_count", more_gold, 1);
      check("first_state", dut.state_q, COOLDOWN);
      step;
      check("first_taken_once", gold_taken, 0);
      check("first_count_hold", more_gold, 1);
      collision_tank_gold = 1'b0;
      ng;
      check("ng_count", more_gold, 0);
      check("ng_state", dut.state_q, ARMED);
      mask = 0;
      collision_tank_gold = 1'b1;
      for (int f = 1; f <= 20; f++) begin
         repeat (3) step;
         sof;
         if (gold_taken) mask[f] = 1'b1;
         repeat (2) step;
      end
      collision_tank_gold = 1'b0;
      check("frames_mask", mask, 32'h0008_0402);
      check("frames_count", more_gold, 3);
      ng;
      collect(1'b0); check("c1", more_gold, 1); cool;
      check("cool_armed", dut.state_q, ARMED);
      check("no_decay", more_gold, 1);
      collect(1'b0); check("c2", more_gold, 2); cool;
      collect(1'b0); check("c3", more_gold, 3); check("c3_full", gold_full, 0); cool;
      collect(1'b0); check("c4", more_gold, 4); check("c4_full", gold_full, 1); cool;
      collect(1'b0);
      check("sat_taken", gold_taken, 1);
      check("sat_count", more_gold, 4);
      check("sat_full", gold_full, 1);
      cool;
      spend;
      check("sp4_ack", {spend_ack, spend_nack}, 2'b10);
      check("sp4_count", more_gold, 2);
      check("sp4_full", gold_full, 0);
      step;
      check("sp_ack_once", spend_ack, 0);
      collect(1'b0); cool;
      spend;
      check("sp3_ack", {spend_ack, spend_nack}, 2'b10);
      check("sp3_count", more_gold, 1);
      spend;
      check("sp1_nack", {spend_ack, spend_nack}, 2'b01);
      check("sp1_count", more_gold, 1);
      step;
      check("sp_nack_once", spend_nack, 0);
      collect(1'b0); cool;
      collect(1'b0); cool;
      collect(1'b0); cool;
      check("refill", more_gold, 4);
      collect(1'b1);
      check("both_pulses", {gold_taken, spend_ack, spend_nack}, 3'b110);
      check("both_count", more_gold, 3);
      check("both_state", dut.state_q, COOLDOWN);
      new_game = 1'b1;
      spend_req = 1'b1;
      step;
      new_game = 1'b0;
      spend_req = 1'b0;
      check("ngcd_count", more_gold, 0);
      check("ngcd_pulses", {spend_ack, spend_nack}, 0);
      check("ngcd_state", dut.state_q, ARMED);
      collect(1'b0);
      check("ngcd_collect", more_gold, 1);
      check("ngcd_taken", gold_taken, 1);
      spend;
      check("sp0_nack", {spend_ack, spend_nack}, 2'b01);
      ng;
      collision_tank_gold = 1'b1;
      step;
      collision_tank_gold = 1'b0;
      startOfFrame = 1'b1;
      new_game = 1'b1;
      step;
      startOfFrame = 1'b0;
      new_game = 1'b0;
      check("ng_commit_taken", gold_taken, 0);
      check("ng_commit_count", more_gold, 0);
      check("ng_commit_state", dut.state_q, ARMED);
      collect(1'b0);
      check("pre_rst", more_gold, 1);
      #2 resetN = 1'b0;
      #1;
      check("async_rst_count", more_gold, 0);
      check("async_rst_state", dut.state_q, ARMED);
      step;
      resetN = 1'b1;
      step;
      collect(1'b0);
      check("post_rst_taken", gold_taken, 1);
      check("post_rst_count", more_gold, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
